alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Multi-cycle issue controller that drives the 32-bit ALU's operand, control-line and shift-amount inputs and consumes its `sum`/`zout` outputs. It accepts one decoded-register instruction at a time over a valid/ready handshake and maps opcode/funct onto the 3-bit ALU control line. It registers the ALU result and zero flag and returns result, branch decision and error status over a second valid/ready handshake. It sits between the fetch/register-read stage and write-back in the multi-cycle datapath.

## Interface
Parameters: none; all widths are fixed by the MIPS ISA (32-bit data, 5-bit shamt, 3-bit ALU control).

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instr`  in  32  instruction word; fields: op[31:26], shamt[10:6], funct[5:0], imm[15:0].
- `rs_val`  in  32  rs register value.
- `rt_val`  in  32  rt register value.
- `instr_valid`  in  1  request valid.
- `instr_ready`  out  1  controller can accept a request.
- `alu_a`  out  32  ALU operand a (registered).
- `alu_b`  out  32  ALU operand b (registered).
- `alu_shamt`  out  5  ALU shift amount (registered).
- `alu_gin`  out  3  ALU control line (registered).
- `alu_sum`  in  32  ALU result.
- `alu_zout`  in  1  ALU zero flag.
- `result`  out  32  captured ALU result.
- `branch_taken`  out  1  beq condition met.
- `illegal`  out  1  unsupported opcode/funct.
- `result_valid`  out  1  response valid.
- `result_ready`  in  1  downstream accepts response.

## Operation
- States are IDLE, EXEC and DONE.
  - IDLE → EXEC on `instr_valid & instr_ready`.
  - EXEC → DONE unconditionally.
  - DONE → IDLE on `result_ready`.
- `instr_ready` = (state == IDLE). `result_valid` = (state == DONE).
- On accept, decode `instr` and load `alu_a`, `alu_b`, `alu_shamt` and `alu_gin` on the same edge.
- Decode, op = 0x00 (R-type), selected by funct. All load `alu_a = rs_val`, `alu_b = rt_val`, `alu_shamt = instr[10:6]`.
  - 0x20 add → gin 010.
  - 0x22 sub → gin 110.
  - 0x24 and → gin 000.
  - 0x25 or → gin 001.
  - 0x2A slt → gin 111.
  - 0x02 srl → gin 011.
- Decode, I-type:
  - op 0x23 lw / 0x2B sw: gin 010; `alu_b = {{16{imm[15]}}, imm}`; `alu_shamt = 0`.
  - op 0x04 beq: gin 110; `alu_b = rt_val`; `alu_shamt = 0`.
- Any other op/funct:
  - Load gin 010, `alu_a = 0`, `alu_b = 0`.
  - Set the pending illegal flag.
  - The request still completes through EXEC and DONE.
- On the EXEC → DONE edge, capture the response:
  - `result ← alu_sum`.
  - `branch_taken ← alu_zout & (op == beq)`.
  - `illegal ← pending flag`.
- For illegal requests `result` is forced to 0.
- Response fields hold stable for the whole of DONE.
- ALU-facing registers hold their values until the next accept.
  - `alu_shamt` never changes on any edge where `alu_b` and `alu_gin` do not also load.
- Arithmetic is performed only in the ALU; this block does no math except sign extension.

## Timing
- Reset (`rst_n` low, asynchronous):
  - state = IDLE, so `instr_ready` = 1 and `result_valid` = 0.
  - `alu_a` = 0, `alu_b` = 0, `alu_shamt` = 0, `alu_gin` = 010.
  - `result` = 0, `branch_taken` = 0, `illegal` = 0.
- Latency:
  - Accept at edge N.
  - ALU inputs are valid in cycle N+1 (EXEC).
  - Capture at edge N+1.
  - `result_valid` is high from edge N+1 until the edge on which `result_ready` = 1.
- Minimum interval between accepts is 3 cycles. There is no new accept in the cycle that DONE retires; `instr_ready` rises on the following cycle.
- Backpressure: `result_ready` low holds DONE indefinitely. All outputs are stable during the hold and no new request is accepted.
- `instr_valid` outside IDLE is ignored and not queued.
- `rst_n` asserted in any state aborts the request and forces the reset values immediately, with no response issued. Deassertion returns to IDLE with `instr_ready` = 1.
- `result_ready` high while in IDLE or EXEC has no effect.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-EXEC → outputs go to reset values without waiting for a clock edge; after release `instr_ready` = 1 and `alu_gin` = 010.
- **add:** add, rs = 5, rt = 7 → gin 010 in EXEC; `result_valid` one cycle after EXEC with `result` = 12 and `illegal` = 0.
- **slt and srl:**
  - slt, rs = 0xFFFFFFFF, rt = 1 → `result` = 1.
  - srl, rt = 0x80000000, shamt = 4 → `result` = 0x08000000; `alu_shamt` = 4 in the same cycle as gin 011.
- **beq:**
  - rs = rt = 0x1234 → `branch_taken` = 1, `result` = 0.
  - rs = 3, rt = 4 → `branch_taken` = 0, `result` = 0xFFFFFFFF.
- **lw address:** lw, rs = 0x100, imm = 0xFFFC → `alu_b` = 0xFFFFFFFC, `result` = 0xFC.
- **Backpressure and illegal:** op 0x3F with `result_ready` held low for 5 cycles → DONE held with `illegal` = 1 and `result` = 0; a second `instr_valid` during the hold is not accepted; DONE retires on the `result_ready` edge.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: decodes one instruction at a time, drives the ALU inputs, and returns
// the registered result, branch decision and illegal flag over a valid/ready handshake.
module alu_issue_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_shamt,
    output logic [2:0]  alu_gin,
    input  logic [31:0] alu_sum,
    input  logic        alu_zout,
    output logic [31:0] result,
    output logic        branch_taken,
    output logic        illegal,
    output logic        result_valid,
    input  logic        result_ready
);
    localparam logic [5:0] OP_R   = 6'h00;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_BEQ = 6'h04;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t state, state_nx;

    logic [5:0]  op, funct;
    logic [31:0] dec_a, dec_b;
    logic [4:0]  dec_shamt;
    logic [2:0]  dec_gin;
    logic        dec_ill, pend_ill, pend_beq, accept;

    assign op           = instr[31:26];
    assign funct        = instr[5:0];
    assign instr_ready  = (state == IDLE);
    assign result_valid = (state == DONE);
    assign accept       = instr_valid & instr_ready;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? EXEC : IDLE;
            EXEC:    state_nx = DONE;
            DONE:    state_nx = result_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        dec_ill   = 1'b0;
        dec_gin   = 3'b010;
        dec_a     = rs_val;
        dec_b     = rt_val;
        dec_shamt = 5'd0;
        case (op)
            OP_R: begin
                dec_shamt = instr[10:6];
                case (funct)
                    6'h20:   dec_gin = 3'b010;
                    6'h22:   dec_gin = 3'b110;
                    6'h24:   dec_gin = 3'b000;
                    6'h25:   dec_gin = 3'b001;
                    6'h2A:   dec_gin = 3'b111;
                    6'h02:   dec_gin = 3'b011;
                    default: dec_ill = 1'b1;
                endcase
            end
            OP_LW, OP_SW: dec_b = {{16{instr[15]}}, instr[15:0]};
            OP_BEQ:       dec_gin = 3'b110;
            default:      dec_ill = 1'b1;
        endcase
        // Unsupported requests still run through the ALU, but on harmless zero operands
        if (dec_ill) begin
            dec_gin   = 3'b010;
            dec_a     = 32'd0;
            dec_b     = 32'd0;
            dec_shamt = 5'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            alu_a        <= 32'd0;
            alu_b        <= 32'd0;
            alu_shamt    <= 5'd0;
            alu_gin      <= 3'b010;
            pend_ill     <= 1'b0;
            pend_beq     <= 1'b0;
            result       <= 32'd0;
            branch_taken <= 1'b0;
            illegal      <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                alu_a     <= dec_a;
                alu_b     <= dec_b;
                alu_shamt <= dec_shamt;
                alu_gin   <= dec_gin;
                pend_ill  <= dec_ill;
                pend_beq  <= (op == OP_BEQ);
            end
            if (state == EXEC) begin
                result       <= pend_ill ? 32'd0 : alu_sum;
                branch_taken <= alu_zout & pend_beq;
                illegal      <= pend_ill;
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: drives directed and random requests through alu_issue_ctrl with a
// behavioural ALU attached, comparing against an instruction-level reference model.
module tb_alu_issue_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = '0, rs_val = '0, rt_val = '0;
    logic        instr_valid = 1'b0, result_ready = 1'b0;
    logic        instr_ready, branch_taken, illegal, result_valid, alu_zout;
    logic [31:0] alu_a, alu_b, alu_sum, result;
    logic [4:0]  alu_shamt;
    logic [2:0]  alu_gin;
    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] result;
        logic        taken;
        logic        ill;
        logic [2:0]  gin;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  shamt;
    } exp_t;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .rs_val(rs_val), .rt_val(rt_val),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .alu_a(alu_a), .alu_b(alu_b),
        .alu_shamt(alu_shamt), .alu_gin(alu_gin), .alu_sum(alu_sum), .alu_zout(alu_zout),
        .result(result), .branch_taken(branch_taken), .illegal(illegal),
        .result_valid(result_valid), .result_ready(result_ready)
    );

    // The ALU the controller is wired to
    always_comb begin
        alu_sum = 32'd0;
        case (alu_gin)
            3'b010: alu_sum = alu_a + alu_b;
            3'b110: alu_sum = alu_a - alu_b;
            3'b000: alu_sum = alu_a & alu_b;
            3'b001: alu_sum = alu_a | alu_b;
            3'b111: alu_sum = {31'd0, $signed(alu_a) < $signed(alu_b)};
            3'b011: alu_sum = alu_b >> alu_shamt;
            default: alu_sum = 32'd0;
        endcase
    end
    assign alu_zout = (alu_sum == 32'd0);

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        exp_t m;
        logic [5:0]  op = ins[31:26];
        logic [5:0]  fn = ins[5:0];
        logic [4:0]  sh = ins[10:6];
        logic [31:0] sx = {{16{ins[15]}}, ins[15:0]};
        m = '{result: 32'd0, taken: 1'b0, ill: 1'b1, gin: 3'b010, a: 32'd0, b: 32'd0, shamt: 5'd0};
        if (op == 6'h00 && fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h02}) begin
            m.ill = 1'b0; m.a = rs; m.b = rt; m.shamt = sh;
            if (fn == 6'h20) begin m.gin = 3'b010; m.result = rs + rt; end
            if (fn == 6'h22) begin m.gin = 3'b110; m.result = rs - rt; end
            if (fn == 6'h24) begin m.gin = 3'b000; m.result = rs & rt; end
            if (fn == 6'h25) begin m.gin = 3'b001; m.result = rs | rt; end
            if (fn == 6'h2A) begin m.gin = 3'b111; m.result = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0; end
            if (fn == 6'h02) begin m.gin = 3'b011; m.result = rt >> sh; end
        end else if (op == 6'h23 || op == 6'h2B) begin
            m.ill = 1'b0; m.a = rs; m.b = sx; m.result = rs + sx;
        end else if (op == 6'h04) begin
            m.ill = 1'b0; m.gin = 3'b110; m.a = rs; m.b = rt; m.result = rs - rt; m.taken = (rs == rt);
        end
        return m;
    endfunction

    // One full request: accept, EXEC, DONE held for `hold` extra cycles, retire
    task automatic do_op(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                         input int hold, input bit keep);
        exp_t e = model(ins, rs, rt);
        @(negedge clk);
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got %b want 1", instr_ready); end
        instr = ins; rs_val = rs; rt_val = rt; instr_valid = 1'b1;
        @(posedge clk); #1;
        if (!keep) instr_valid = 1'b0;
        instr = $urandom; rs_val = $urandom; rt_val = $urandom;
        checks++; if (instr_ready !== 1'b0 || result_valid !== 1'b0) begin errors++; $display("FAIL exec_hs ins=%h got rdy=%b vld=%b want 0 0", ins, instr_ready, result_valid); end
        checks++; if (alu_gin !== e.gin) begin errors++; $display("FAIL exec_gin ins=%h got %b want %b", ins, alu_gin, e.gin); end
        checks++; if (alu_a !== e.a || alu_b !== e.b) begin errors++; $display("FAIL exec_ops ins=%h got a=%h b=%h want a=%h b=%h", ins, alu_a, alu_b, e.a, e.b); end
        if (!e.ill) begin
            checks++; if (alu_shamt !== e.shamt) begin errors++; $display("FAIL exec_shamt ins=%h got %0d want %0d", ins, alu_shamt, e.shamt); end
        end
        @(posedge clk); #1;
        for (int i = 0; i <= hold; i++) begin
            checks++; if (result_valid !== 1'b1 || instr_ready !== 1'b0) begin errors++; $display("FAIL done_hs ins=%h cyc=%0d got vld=%b rdy=%b want 1 0", ins, i, result_valid, instr_ready); end
            checks++; if (result !== e.result || branch_taken !== e.taken || illegal !== e.ill) begin
                errors++; $display("FAIL done_resp ins=%h rs=%h rt=%h cyc=%0d got res=%h bt=%b ill=%b want res=%h bt=%b ill=%b",
                                   ins, rs, rt, i, result, branch_taken, illegal, e.result, e.taken, e.ill);
            end
            checks++; if (alu_gin !== e.gin || alu_a !== e.a || alu_b !== e.b) begin errors++; $display("FAIL done_alu_hold ins=%h got gin=%b a=%h b=%h want gin=%b a=%h b=%h", ins, alu_gin, alu_a, alu_b, e.gin, e.a, e.b); end
            if (i == hold) result_ready = 1'b1;
            @(posedge clk); #1;
        end
        result_ready = 1'b0;
        instr_valid = 1'b0;
        checks++; if (result_valid !== 1'b0 || instr_ready !== 1'b1) begin errors++; $display("FAIL retire ins=%h got vld=%b rdy=%b want 0 1", ins, result_valid, instr_ready); end
    endtask

    function automatic logic [31:0] mk_r(input logic [5:0] fn, input logic [4:0] sh);
        logic [31:0] w = $urandom;
        return {6'h00, w[25:11], sh, fn};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [15:0] imm);
        logic [31:0] w = $urandom;
        return {op, w[25:16], imm};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (instr_ready !== 1'b1 || result_valid !== 1'b0) begin errors++; $display("FAIL rst_hs got rdy=%b vld=%b want 1 0", instr_ready, result_valid); end
        checks++; if (alu_a !== 0 || alu_b !== 0 || alu_shamt !== 0 || alu_gin !== 3'b010) begin errors++; $display("FAIL rst_alu got a=%h b=%h sh=%0d gin=%b want 0 0 0 010", alu_a, alu_b, alu_shamt, alu_gin); end
        checks++; if (result !== 0 || branch_taken !== 0 || illegal !== 0) begin errors++; $display("FAIL rst_resp got res=%h bt=%b ill=%b want 0 0 0", result, branch_taken, illegal); end
        @(negedge clk); rst_n = 1'b1;
        instr = mk_r(6'h20, 5'd9); rs_val = 32'd5; rt_val = 32'd7; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        checks++; if (alu_a !== 32'd5 || alu_shamt !== 5'd9) begin errors++; $display("FAIL pre_abort got a=%h sh=%0d want 5 9", alu_a, alu_shamt); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (alu_a !== 0 || alu_b !== 0 || alu_shamt !== 0 || alu_gin !== 3'b010 || instr_ready !== 1'b1 || result_valid !== 1'b0) begin
            errors++; $display("FAIL async_rst got a=%h b=%h sh=%0d gin=%b rdy=%b vld=%b want 0 0 0 010 1 0", alu_a, alu_b, alu_shamt, alu_gin, instr_ready, result_valid);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (instr_ready !== 1'b1 || result_valid !== 1'b0 || alu_gin !== 3'b010) begin errors++; $display("FAIL post_rst got rdy=%b vld=%b gin=%b want 1 0 010", instr_ready, result_valid, alu_gin); end
    endtask

    task automatic test_directed();
        do_op(mk_r(6'h20, 5'd0), 32'd5, 32'd7, 0, 1'b0);
        do_op(mk_r(6'h2A, 5'd0), 32'hFFFF_FFFF, 32'd1, 0, 1'b0);
        do_op(mk_r(6'h02, 5'd4), 32'd0, 32'h8000_0000, 0, 1'b0);
        do_op(mk_i(6'h04, 16'h0010), 32'h1234, 32'h1234, 0, 1'b0);
        do_op(mk_i(6'h04, 16'h0010), 32'd3, 32'd4, 0, 1'b0);
        do_op(mk_i(6'h23, 16'hFFFC), 32'h100, 32'h55, 1, 1'b0);
    endtask

    task automatic test_backpressure_illegal();
        do_op(mk_i(6'h3F, 16'h1234), 32'hDEAD_BEEF, 32'h1111_1111, 5, 1'b1);
        do_op(mk_r(6'h21, 5'd3), 32'd9, 32'd9, 2, 1'b1);
    endtask

    task automatic test_random();
        logic [5:0] fns [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h02};
        for (int n = 0; n < 60; n++) begin
            logic [31:0] ins, rs, rt;
            logic [5:0]  op;
            int k = $urandom_range(0, 9);
            rs = $urandom; rt = $urandom;
            if (k < 6) ins = mk_r(fns[k], 5'($urandom));
            else if (k == 6) ins = mk_i(6'h23, 16'($urandom));
            else if (k == 7) ins = mk_i(6'h2B, 16'($urandom));
            else if (k == 8) begin ins = mk_i(6'h04, 16'($urandom)); if ($urandom_range(0, 1) == 1) rt = rs; end
            else begin
                do op = 6'($urandom); while (op inside {6'h00, 6'h23, 6'h2B, 6'h04});
                ins = mk_i(op, 16'($urandom));
            end
            do_op(ins, rs, rt, $urandom_range(0, 3), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure_illegal();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
